// File: rtl/programmable_delay_line.sv
// programmable_delay_line: WIDTH-bit word delayed by a runtime-selectable 0..MAX_DELAY enabled cycles
module programmable_delay_line #(
  parameter int WIDTH = 8,
  parameter int MAX_DELAY = 16,
  localparam int SW = $clog2(MAX_DELAY) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SW-1:0]    delay_sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             sel_err
);
  localparam int AW = $clog2(MAX_DELAY);
  logic [WIDTH-1:0] mem [MAX_DELAY];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_addr;
  logic [SW-1:0]    act_d_q, act_d_d, clamp_sel, fill_q, fill_d, fill_inc;
  logic [WIDTH-1:0] dout_q, dout_d, rd_word;
  logic             valid_q, valid_d, err_q, err_d, flush, over;
  always_comb begin
    over      = delay_sel > SW'(MAX_DELAY);
    clamp_sel = over ? SW'(MAX_DELAY) : delay_sel;
    flush     = clamp_sel != act_d_q;
    act_d_d   = clamp_sel;
    err_d     = err_q | over;
    wr_ptr_d  = en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    fill_inc  = (fill_q == SW'(MAX_DELAY)) ? fill_q : fill_q + SW'(1);
    fill_d    = flush ? SW'(en) : en ? fill_inc : fill_q;
    // Slot written D-1 enabled edges ago; D=1 forwards the word being written now
    rd_addr   = wr_ptr_q - AW'(act_d_q - SW'(1));
    rd_word   = (act_d_q == SW'(1)) ? din : mem[rd_addr];
    valid_d   = flush ? 1'b0 : en ? (fill_d >= act_d_q) : valid_q;
    dout_d    = (en && !flush && fill_d >= act_d_q && act_d_q != '0) ? rd_word : dout_q;
  end
  always_ff @(posedge clk)
    if (en) mem[wr_ptr_q] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      act_d_q  <= SW'(1);
      dout_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      act_d_q  <= act_d_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  assign dout       = (act_d_q == '0) ? din : dout_q;
  assign dout_valid = (act_d_q == '0) ? en : valid_q;
  assign sel_err    = err_q;
endmodule
